// File: rtl/mmm_redc_90b.sv
// ============================================================================
// Module      : mmm_redc_90b
// Description : Word-serial Montgomery reduction stage for the 90-bit NLP
//               modular multiplier. Takes the raw product T = A*B and
//               returns T * 2^-MDW mod M, fully reduced into [0, M).
//               The digit loop is 18 bits wide with one multiplier pair
//               per cycle: 18x18 for the quotient digit, 18x90 for the
//               accumulate.
// Ports       : i_clk       clock
//               i_rst       asynchronous active-high reset
//               i_t_vld     product valid
//               o_t_rdy     block idle, can accept a product
//               i_t         product T (IDW bits), T < M*2^MDW
//               i_m         modulus M (odd)
//               i_minv      -M^-1 mod 2^DGW
//               o_res_vld   result valid
//               i_res_rdy   downstream accepts result
//               o_res       T*2^-MDW mod M
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mmm_redc_90b #(
  parameter int IDW  = 181,
  parameter int MDW  = 90,
  parameter int DGW  = 18,
  parameter int NDIG = 5,
  parameter int TW   = 183
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_t_vld,
  output logic           o_t_rdy,
  input  logic [IDW-1:0] i_t,
  input  logic [MDW-1:0] i_m,
  input  logic [DGW-1:0] i_minv,
  output logic           o_res_vld,
  input  logic           i_res_rdy,
  output logic [MDW-1:0] o_res
);

  localparam int QMW  = DGW + MDW;                       // q*m product width
  localparam int CNTW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CNTW-1:0] C_CNT_LAST = CNTW'(NDIG - 1);
  localparam logic [CNTW-1:0] C_CNT_ONE  = CNTW'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_QCALC = 3'd1,
    S_ACC   = 3'd2,
    S_SUB   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   t_q, t_d;
  logic [DGW-1:0]  q_q, q_d;
  logic [MDW-1:0]  m_q, m_d;
  logic [DGW-1:0]  minv_q, minv_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [MDW-1:0]  res_q, res_d;
  logic            res_vld_q, res_vld_d;
  logic            t_rdy_q, t_rdy_d;

  // Datapath: the only multipliers in the block.
  logic [DGW-1:0]  q_digit;   // (t mod 2^DGW) * minv, truncated to one digit
  logic [QMW-1:0]  qm_prod;   // 18x90 partial product
  logic [TW-1:0]   acc_sum;   // t + q*m; low DGW bits are zero by construction
  logic            t_ge_m;
  logic [MDW-1:0]  t_minus_m;

  // Truncating 18x18 multiply: only the low digit of the product matters.
  assign q_digit = t_q[DGW-1:0] * minv_q;

  assign qm_prod = {{MDW{1'b0}}, q_q} * {{DGW{1'b0}}, m_q};
  assign acc_sum = t_q + {{(TW-QMW){1'b0}}, qm_prod};

  // After NDIG digits t < 2M, so one MDW+1-bit compare and one conditional
  // subtract finish the reduction. The subtract is only taken when the
  // result is below M, so MDW bits of difference are exact.
  assign t_ge_m    = t_q[MDW:0] >= {1'b0, m_q};
  assign t_minus_m = t_q[MDW-1:0] - m_q;

  always_comb begin
    state_d   = state_q;
    t_d       = t_q;
    q_d       = q_q;
    m_d       = m_q;
    minv_d    = minv_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    res_vld_d = res_vld_q;
    t_rdy_d   = t_rdy_q;

    case (state_q)
      S_IDLE: begin
        t_rdy_d = 1'b1;
        if (i_t_vld && t_rdy_q) begin
          t_d     = {{(TW-IDW){1'b0}}, i_t};
          m_d     = i_m;
          minv_d  = i_minv;
          cnt_d   = '0;
          t_rdy_d = 1'b0;
          state_d = S_QCALC;
        end
      end

      S_QCALC: begin
        q_d     = q_digit;
        state_d = S_ACC;
      end

      S_ACC: begin
        // Exact division by 2^DGW: the low digit of acc_sum is zero.
        t_d   = acc_sum >> DGW;
        cnt_d = cnt_q + C_CNT_ONE;
        // Loop bound is a pure count, so an even modulus still terminates.
        if (cnt_q == C_CNT_LAST) begin
          state_d = S_SUB;
        end else begin
          state_d = S_QCALC;
        end
      end

      S_SUB: begin
        res_d     = t_ge_m ? t_minus_m : t_q[MDW-1:0];
        res_vld_d = 1'b1;
        state_d   = S_DONE;
      end

      S_DONE: begin
        // Result held until the downstream handshake; the next job is
        // admitted from the cycle after it.
        if (i_res_rdy) begin
          res_vld_d = 1'b0;
          t_rdy_d   = 1'b1;
          state_d   = S_IDLE;
        end
      end

      default: begin
        res_vld_d = 1'b0;
        t_rdy_d   = 1'b1;
        state_d   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      t_q       <= '0;
      q_q       <= '0;
      m_q       <= '0;
      minv_q    <= '0;
      cnt_q     <= '0;
      res_q     <= '0;
      res_vld_q <= 1'b0;
      t_rdy_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      t_q       <= t_d;
      q_q       <= q_d;
      m_q       <= m_d;
      minv_q    <= minv_d;
      cnt_q     <= cnt_d;
      res_q     <= res_d;
      res_vld_q <= res_vld_d;
      t_rdy_q   <= t_rdy_d;
    end
  end

  assign o_t_rdy   = t_rdy_q;
  assign o_res_vld = res_vld_q;
  assign o_res     = res_q;

endmodule

`default_nettype wire

// File: tb/tb_mmm_redc_90b.sv
// ============================================================================
// Module      : tb_mmm_redc_90b
// Description : Self-checking bench for mmm_redc_90b. Directed vectors with
//               hand-derived results, latency / backpressure / mid-job reset
//               sequences, and random jobs scored against a whole-number
//               model of T * 2^-90 mod M.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mmm_redc_90b;

  localparam int IDW = 181;
  localparam int MDW = 90;
  localparam int DGW = 18;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           i_t_vld = 1'b0;
  logic           o_t_rdy;
  logic [IDW-1:0] i_t = '0;
  logic [MDW-1:0] i_m = '0;
  logic [DGW-1:0] i_minv = '0;
  logic           o_res_vld;
  logic           i_res_rdy = 1'b0;
  logic [MDW-1:0] o_res;

  always #5 clk = ~clk;

  mmm_redc_90b dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_t_vld   (i_t_vld),
    .o_t_rdy   (o_t_rdy),
    .i_t       (i_t),
    .i_m       (i_m),
    .i_minv    (i_minv),
    .o_res_vld (o_res_vld),
    .i_res_rdy (i_res_rdy),
    .o_res     (o_res)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int n_sent = 0;
  int n_res  = 0;
  int rdy_mode = 0;          // 0: ready high, 1: random, 2: held low
  logic [MDW-1:0] sb[$];
  logic [MDW-1:0] mon_exp;

  typedef struct {
    logic [IDW-1:0] t;
    logic [MDW-1:0] m;
    logic [DGW-1:0] minv;
    logic [MDW-1:0] exp;
  } vec_t;
  vec_t vecs[9];

  task automatic check(input string name, input logic [MDW-1:0] act, input logic [MDW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // -M^-1 mod 2^90 by Newton iteration (3 -> 6 -> ... -> 192 correct bits).
  function automatic logic [MDW-1:0] neg_inv(input logic [MDW-1:0] m);
    logic [MDW-1:0] x;
    x = m;
    for (int i = 0; i < 6; i++) x = x * (90'd2 - m * x);
    return 90'd0 - x;
  endfunction

  // Reference: (T mod M) * R^-1 mod M, with R^-1 = (1 + M*k) / R.
  function automatic logic [MDW-1:0] model(input logic [IDW-1:0] t, input logic [MDW-1:0] m);
    logic [MDW-1:0] k;
    logic [IDW-1:0] mw, p, rinv, tr, r;
    k    = neg_inv(m);
    mw   = {91'b0, m};
    p    = mw * {91'b0, k} + 181'd1;
    rinv = (p >> 90) % mw;
    tr   = t % mw;
    r    = (tr * rinv) % mw;
    return r[MDW-1:0];
  endfunction

  // Result monitor: ready is updated first so that a result seen here is
  // exactly the one the next rising edge consumes.
  always @(negedge clk) begin
    case (rdy_mode)
      0:       i_res_rdy = 1'b1;
      1:       i_res_rdy = ($urandom_range(0, 3) != 0);
      default: i_res_rdy = 1'b0;
    endcase
    if (o_res_vld && i_res_rdy) begin
      n_res++;
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_result: got %h, expected no result", o_res);
      end else begin
        mon_exp = sb.pop_front();
        check("result", o_res, mon_exp);
      end
    end
  end

  task automatic send(input logic [IDW-1:0] t, input logic [MDW-1:0] m,
                      input logic [DGW-1:0] mi, input logic [MDW-1:0] exp, input int gap);
    int w;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    i_t = t; i_m = m; i_minv = mi; i_t_vld = 1'b1;
    w = 0;
    while (!o_t_rdy && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (!o_t_rdy) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: got o_t_rdy=0 for %0d cycles, expected 1", w);
      i_t_vld = 1'b0;
      return;
    end
    sb.push_back(exp);
    n_sent++;
    @(posedge clk);
    @(negedge clk);
    i_t_vld = 1'b0;
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d results pending, expected 0", sb.size());
    end
  endtask

  initial begin
    #900us;
    $display("FAIL watchdog: got no completion, expected finish");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [MDW-1:0] m1, m2, k, m, a, b, held, ex;
    logic [95:0]    r96;
    logic [IDW-1:0] t;
    logic [DGW-1:0] mi;
    int n;

    m1 = (90'd1 << 89) | 90'd1;   // 2^89+1: R = -2 mod M, R^-1 = 2^88
    m2 = {MDW{1'b1}};             // 2^90-1: R = 1 mod M, R^-1 = 1
    vecs[0] = '{t: 181'd0,                               m: m1, minv: 18'h3FFFF, exp: 90'd0};
    vecs[1] = '{t: 181'd1 << 90,                         m: m1, minv: 18'h3FFFF, exp: 90'd1};
    vecs[2] = '{t: {91'b0, m1},                          m: m1, minv: 18'h3FFFF, exp: 90'd0};
    vecs[3] = '{t: 181'd1,                               m: m1, minv: 18'h3FFFF, exp: 90'd1 << 88};
    vecs[4] = '{t: 181'd1 << 91,                         m: m1, minv: 18'h3FFFF, exp: 90'd2};
    vecs[5] = '{t: ({91'b0, m1} << 90) - 181'd1,         m: m1, minv: 18'h3FFFF, exp: (90'd1 << 88) + 90'd1};
    vecs[6] = '{t: 181'd1 << 90,                         m: m2, minv: 18'd1,     exp: 90'd1};
    vecs[7] = '{t: {91'b0, m2 - 90'd1} * {91'b0, m2 - 90'd1}, m: m2, minv: 18'd1, exp: 90'd1};
    vecs[8] = '{t: 181'd5,                               m: m2, minv: 18'd1,     exp: 90'd5};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_res_vld", o_res_vld, 0);
    check("reset_res", o_res, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_t_rdy", o_t_rdy, 1);

    // Directed vectors; first one also measures accept-to-valid latency
    rdy_mode = 0;
    for (int i = 0; i < 9; i++) begin
      send(vecs[i].t, vecs[i].m, vecs[i].minv, vecs[i].exp, 0);
      if (i == 0) begin
        n = 0;
        while (!o_res_vld && n < 40) begin
          @(posedge clk);
          #1;
          n++;
        end
        check("latency", n, 11);
      end
      wait_drain();
    end

    // Backpressure: result held for 6 cycles, stray input pulse ignored
    rdy_mode = 2;
    send(181'd1 << 90, m1, 18'h3FFFF, 90'd1, 0);
    n = 0;
    while (!o_res_vld && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("bp_vld_seen", o_res_vld, 1);
    held = o_res;
    for (int c = 0; c < 6; c++) begin
      check("bp_vld_hold", o_res_vld, 1);
      check("bp_res_hold", o_res, held);
      check("bp_t_rdy_low", o_t_rdy, 0);
      if (c == 2) begin
        i_t = 181'd12345; i_m = m2; i_minv = 18'd1; i_t_vld = 1'b1;
      end
      if (c == 3) i_t_vld = 1'b0;
      @(negedge clk);
    end
    #1 rdy_mode = 0;
    @(negedge clk);
    @(posedge clk);
    #1;
    check("bp_t_rdy_after", o_t_rdy, 1);
    check("bp_vld_after", o_res_vld, 0);
    wait_drain();

    // Reset in the middle of a job
    send({91'b0, m1}, m1, 18'h3FFFF, 90'd0, 0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_res_vld", o_res_vld, 0);
    check("midrst_res", o_res, 0);
    check("midrst_t_rdy", o_t_rdy, 1);
    sb.delete();
    n_sent--;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    send(181'd1 << 91, m1, 18'h3FFFF, 90'd2, 0);
    wait_drain();

    // Random jobs with random gaps and random downstream ready
    rdy_mode = 1;
    for (int j = 0; j < 2000; j++) begin
      r96 = {$urandom, $urandom, $urandom};
      m = r96[MDW-1:0];
      m[0] = 1'b1;
      if (m == 90'd1) m = 90'd3;
      r96 = {$urandom, $urandom, $urandom};
      a = r96[MDW-1:0] % m;
      r96 = {$urandom, $urandom, $urandom};
      b = r96[MDW-1:0] % m;
      t = {91'b0, a} * {91'b0, b};
      k = neg_inv(m);
      mi = k[DGW-1:0];
      ex = model(t, m);
      send(t, m, mi, ex, $urandom_range(0, 3));
    end
    wait_drain();
    rdy_mode = 0;
    repeat (20) @(negedge clk);
    check("result_count", n_res, n_sent);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
